// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and data-memory signals of the load/store unit
interface load_store_unit_if;
  logic req_valid, req_ready, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic mem_read, mem_write;
  logic [31:0] endereco, write_data, read_data;
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, read_data,
    input req_ready, rsp_valid, rsp_rdata, rsp_error, mem_read, mem_write, endereco, write_data
  );
  modport slave (
    input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_read, mem_write, endereco, write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store FSM on a word-indexed memory; MISALIGN_TRAP_EN makes misaligned accesses errors
module load_store_unit #(
  parameter int WORD_ADDR_W = 5
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state_q, state_d;
  logic write_q, write_d, uns_q, uns_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [31:0] aligned, mask, merged, ext;
  logic [7:0] b;
  logic [15:0] h;
  logic misaligned, bad;
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    aligned = bus.req_addr;
`else
    misaligned = 1'b0;
    aligned = bus.req_size == 2'b01 ? {bus.req_addr[31:1], 1'b0} :
              bus.req_size == 2'b10 ? {bus.req_addr[31:2], 2'b00} : bus.req_addr;
`endif
    bad = bus.req_size == 2'b11 || (|bus.req_addr[31:WORD_ADDR_W+2]) || misaligned;
    b = bus.read_data[{addr_q[1:0], 3'b000} +: 8];
    h = bus.read_data[{addr_q[1], 4'b0000} +: 16];
    ext = size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b} :
          size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : bus.read_data;
    mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {addr_q[1:0], 3'b000};
    merged = (bus.read_data & ~mask) | ((data_q << {addr_q[1:0], 3'b000}) & mask);
    state_d = state_q;
    write_d = write_q;
    uns_d = uns_q;
    err_d = err_q;
    size_d = size_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == IDLE && bus.req_valid) begin
      state_d = bad ? RESP : (!bus.req_write || bus.req_size != 2'b10) ? RD : WR;
      write_d = bus.req_write;
      uns_d = bus.req_unsigned;
      err_d = bad;
      size_d = bus.req_size;
      addr_d = aligned;
      data_d = bus.req_wdata;
    end
    if (state_q == RD) begin
      state_d = write_q ? WR : RESP;
      data_d = write_q ? merged : ext;
    end
    if (state_q == WR) state_d = RESP;
    if (state_q == RESP && bus.rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= 32'h0;
      data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      uns_q <= uns_d;
      err_q <= err_d;
      size_q <= size_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign bus.req_ready = state_q == IDLE && !reset;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = (state_q == RESP && !write_q && !err_q) ? data_q : 32'h0;
  assign bus.rsp_error = state_q == RESP && err_q;
  assign bus.mem_read = !reset && state_q != WR;
  assign bus.mem_write = state_q == WR;
  assign bus.write_data = state_q == WR ? data_q : 32'h0;
  assign bus.endereco = (state_q == RD || state_q == WR) ? {2'b00, addr_q[31:2]} : 32'hFFFF_FFFF;
endmodule
